vm1_regfile_wbuf: RTL

- Write buffer and forwarding front-end placed directly upstream of the 64x16 dual-port register-file RAM (vm1_regfile_ram).
- Accepts byte-masked register writes from the microsequencer into a small FIFO and drains one entry per cycle into RAM port A, the only port with byte enables.
- Services reads on RAM port B, which is read-only here, with 1-cycle latency. Bytes still pending in the buffer are forwarded so every read returns coherent data.

---
 rtl/vm1_regfile_pkg.sv | 26 ++
 rtl/vm1_wbuf_fwd.sv | 39 +++
 rtl/vm1_regfile_wbuf.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/vm1_regfile_pkg.sv
// Shared types and constants for the vm1 register-file front-end.
// Build option: VM1_WBUF_COALESCE_EN (tail-merge in the write buffer).
package vm1_regfile_pkg;

    localparam int AW = 6;
    localparam int DW = 16;
    localparam int NB = 2;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [NB-1:0] be;
    } wbuf_entry_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/vm1_wbuf_fwd.sv
// Youngest-match byte-lane forwarding search over the occupied write-buffer entries.
// Build option: none (the buffer contents already reflect VM1_WBUF_COALESCE_EN merges).
module vm1_wbuf_fwd
    import vm1_regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wbuf_entry_t [DEPTH-1:0]    entries,
    input  logic [clog2(DEPTH)-1:0]    head,
    input  logic [clog2(DEPTH):0]      count,
    input  logic [AW-1:0]              rd_addr,
    output logic [NB-1:0]              hit,
    output logic [DW-1:0]              data
);

    localparam int PW = clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] idx;

    // Walk oldest to youngest so a younger match overwrites an older one per lane.
    always_comb begin
        hit  = '0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < count) && (entries[idx].addr == rd_addr)) begin
                for (int b = 0; b < NB; b++) begin
                    if (entries[idx].be[b]) begin
                        hit[b]          = 1'b1;
                        data[8*b +: 8]  = entries[idx].data[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/vm1_regfile_wbuf.sv
// Write buffer with read forwarding in front of the 64x16 dual-port register-file RAM.
// Build option: VM1_WBUF_COALESCE_EN merges a write into a matching, non-draining tail entry.
module vm1_regfile_wbuf
    import vm1_regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [AW-1:0]             wr_addr,
    input  logic [DW-1:0]             wr_data,
    input  logic [NB-1:0]             wr_be,
    input  logic                      rd_valid,
    input  logic [AW-1:0]             rd_addr,
    output logic                      rd_ack,
    output logic [DW-1:0]             rd_data,
    input  logic                      hold,
    output logic                      empty,
    output logic [clog2(DEPTH):0]     count,
    output logic [AW-1:0]             ram_address_a,
    output logic [NB-1:0]             ram_byteena_a,
    output logic [DW-1:0]             ram_data_a,
    output logic                      ram_wren_a,
    output logic [AW-1:0]             ram_address_b,
    output logic [DW-1:0]             ram_data_b,
    output logic                      ram_wren_b,
    input  logic [DW-1:0]             ram_q_b
);

    localparam int PW = clog2(DEPTH);
    localparam int CW = PW + 1;

    wbuf_entry_t [DEPTH-1:0] mem;
    logic [PW-1:0]           head;
    logic [PW-1:0]           tail;
    logic [CW-1:0]           count_q;
    wbuf_entry_t             head_e;

    logic                    full;
    logic                    drain;
    logic                    push;
    logic                    merge;

    logic                    rd_ack_q;
    logic [NB-1:0]           fwd_hit;
    logic [NB-1:0]           fwd_hit_q;
    logic [DW-1:0]           fwd_data;
    logic [DW-1:0]           fwd_data_q;

    assign head_e = mem[head];
    assign full   = (count_q == CW'(DEPTH));
    assign drain  = !hold && (count_q != '0);

`ifdef VM1_WBUF_COALESCE_EN
    logic [PW-1:0] tail_idx;
    wbuf_entry_t   tail_e;
    wbuf_entry_t   merged;
    logic          tail_match;

    assign tail_idx   = tail - PW'(1);
    assign tail_e     = mem[tail_idx];
    assign tail_match = (count_q != '0) && (wr_addr == tail_e.addr);
    // When full the tail can never be the head, so this stays independent of hold.
    assign wr_ready   = !full || tail_match;
    assign merge      = wr_valid && tail_match && !(drain && (count_q == CW'(1)));

    always_comb begin
        merged    = tail_e;
        merged.be = tail_e.be | wr_be;
        for (int b = 0; b < NB; b++) begin
            if (wr_be[b]) begin
                merged.data[8*b +: 8] = wr_data[8*b +: 8];
            end
        end
    end
`else
    assign wr_ready = !full;
    assign merge    = 1'b0;
`endif

    assign push = wr_valid && wr_ready && (wr_be != '0) && !merge;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem     <= '0;
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem[tail] <= '{addr: wr_addr, data: wr_data, be: wr_be};
                tail      <= tail + PW'(1);
            end
`ifdef VM1_WBUF_COALESCE_EN
            if (merge) begin
                mem[tail_idx] <= merged;
            end
`endif
            if (drain) begin
                head <= head + PW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(drain);
        end
    end

    assign ram_wren_a    = drain;
    assign ram_byteena_a = drain ? head_e.be   : '0;
    assign ram_address_a = drain ? head_e.addr : '0;
    assign ram_data_a    = drain ? head_e.data : '0;

    assign ram_address_b = rd_addr;
    assign ram_data_b    = '0;
    assign ram_wren_b    = 1'b0;

    assign count = count_q;
    assign empty = (count_q == '0) && !drain;

    // The draining head is still in mem this cycle, so RAM read-during-write data is never used.
    vm1_wbuf_fwd #(
        .DEPTH (DEPTH)
    ) u_fwd (
        .entries (mem),
        .head    (head),
        .count   (count_q),
        .rd_addr (rd_addr),
        .hit     (fwd_hit),
        .data    (fwd_data)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ack_q   <= 1'b0;
            fwd_hit_q  <= '0;
            fwd_data_q <= '0;
        end else begin
            rd_ack_q <= rd_valid;
            if (rd_valid) begin
                fwd_hit_q  <= fwd_hit;
                fwd_data_q <= fwd_data;
            end
        end
    end

    assign rd_ack = rd_ack_q;

    always_comb begin
        rd_data = '0;
        if (rd_ack_q) begin
            for (int b = 0; b < NB; b++) begin
                rd_data[8*b +: 8] = fwd_hit_q[b] ? fwd_data_q[8*b +: 8] : ram_q_b[8*b +: 8];
            end
        end
    end

endmodule
